tdm_demux: RTL

//  Time-division demultiplexer: receive end of a TDM link whose transmit end is built

---
 rtl/tdm_demux.sv | 105 ++++++++++
 1 files changed

// File: rtl/tdm_demux.sv
// tdm_demux: receive side of a framed TDM link. Each accepted beat is steered
// into a shadow slot, and a completed frame is published to dout atomically
// together with a one-cycle dout_vld strobe. Frame alignment is tracked by a
// two-state HUNT/LOCKED FSM. Alignment faults pulse sync_err.
module tdm_demux #(
  parameter int  WIDTH    = 8,
  parameter int  CHANNELS = 4,
  localparam int SW       = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          din,
  input  logic                      din_vld,
  input  logic                      fsync,
  output logic [CHANNELS*WIDTH-1:0] dout,
  output logic                      dout_vld,
  output logic [SW-1:0]             sel,
  output logic                      locked,
  output logic                      sync_err
);

  localparam int LAST = CHANNELS - 1;

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t                        state_q, state_d;
  logic [SW-1:0]                 sel_q, sel_d;
  // Slot 0 sits at the LSBs. The final slot never needs a shadow because it
  // goes straight into dout together with the stored slots.
  logic [LAST*WIDTH-1:0]         shadow_q, shadow_d;
  logic [CHANNELS*WIDTH-1:0]     dout_q, dout_d;
  logic                          dout_vld_q, dout_vld_d;
  logic                          sync_err_q, sync_err_d;

  // Next-state, slot steering, frame publication and fault detection
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    shadow_d   = shadow_q;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    sync_err_d = 1'b0;
    if (din_vld) begin
      unique case (state_q)
        HUNT: begin
          // Beats without fsync are dropped silently while hunting
          if (fsync) begin
            shadow_d[WIDTH-1:0] = din;
            sel_d               = SW'(1);
            state_d             = LOCKED;
          end
        end
        LOCKED: begin
          if (fsync) begin
            // fsync away from slot 0 is an early frame: restart on this beat
            if (sel_q != '0) sync_err_d = 1'b1;
            shadow_d[WIDTH-1:0] = din;
            sel_d               = SW'(1);
          end else if (sel_q == '0) begin
            // Slot 0 arrived without fsync: alignment lost
            sync_err_d = 1'b1;
            sel_d      = '0;
            state_d    = HUNT;
          end else if (sel_q == SW'(LAST)) begin
            dout_d     = {din, shadow_q};
            dout_vld_d = 1'b1;
            sel_d      = '0;
          end else begin
            for (int k = 1; k < LAST; k++) begin
              if (sel_q == SW'(k)) shadow_d[k*WIDTH +: WIDTH] = din;
            end
            sel_d = sel_q + SW'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // State, shadow and output registers; reset discards any partial frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HUNT;
      sel_q      <= '0;
      shadow_q   <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      shadow_q   <= shadow_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign sel      = sel_q;
  assign locked   = (state_q == LOCKED);
  assign sync_err = sync_err_q;

endmodule
